// File: rtl/decrement_cnt.sv
// decrement_cnt: loadable down-counter with valid/ready load and completion
// handshakes. Parameter T picks the decrement datapath (inferred subtractor
// or mask-and-invert). Optional macro DECREMENT_CNT_RELOAD_EN makes the block
// reload the last accepted start count after every accepted completion.

package libv_pkg;
  typedef enum logic {INFERED, INVZERO} dec_impl_e;
endpackage

module decrement_cnt #(
  parameter int unsigned         W = 32,
  parameter libv_pkg::dec_impl_e T = libv_pkg::INFERED
) (
  input  logic         clk,
  input  logic         arst_n,   // deassertion is expected to be synchronous to clk
  input  logic         ld_vld,
  input  logic [W-1:0] ld_cnt,
  output logic         ld_rdy,
  input  logic         en,
  input  logic         kill,
  output logic         done_vld,
  input  logic         done_rdy,
  output logic [W-1:0] cnt_r,
  output logic         busy_r
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_r, state_nxt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] dec_val;

`ifdef DECREMENT_CNT_RELOAD_EN
  logic [W-1:0] reload_r, reload_nxt;
`endif

  // Bit-reverse so the lowest set bit of x becomes the leading one.
  function automatic logic [W-1:0] bit_rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = x[int'(W) - 1 - i];
    return r;
  endfunction

  // Count leading zeros; an all-zero input returns W.
  function automatic int clz(input logic [W-1:0] x);
    int   n;
    logic found;
    n     = int'(W);
    found = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = int'(W) - 1 - i;
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Expand a bit index into a mask covering bit 0 up to and including it.
  function automatic logic [W-1:0] lo_mask(input int idx);
    logic [W-1:0] m;
    for (int i = 0; i < int'(W); i++) m[i] = (i <= idx);
    return m;
  endfunction

  // Decrement datapath; only consulted in RUN where cnt_r is never zero.
  always_comb begin
    if (T == libv_pkg::INVZERO) dec_val = cnt_r ^ lo_mask(clz(bit_rev(cnt_r)));
    else                        dec_val = cnt_r - W'(1);
  end

  // Next-state and next-count decode; kill overrides every other request.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    state_nxt  = state_r;
    cnt_nxt    = cnt_r;
`ifdef DECREMENT_CNT_RELOAD_EN
    reload_nxt = reload_r;
`endif
    if (kill) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ld_vld) begin
            cnt_nxt   = ld_cnt;
            state_nxt = (ld_cnt == '0) ? DONE : RUN;
`ifdef DECREMENT_CNT_RELOAD_EN
            reload_nxt = ld_cnt;
`endif
          end
        end
        RUN: begin
          if (en) begin
            cnt_nxt = dec_val;
            if (cnt_r == W'(1)) state_nxt = DONE;
          end
        end
        DONE: begin
          if (done_rdy) begin
`ifdef DECREMENT_CNT_RELOAD_EN
            cnt_nxt   = reload_r;
            state_nxt = (reload_r == '0) ? DONE : RUN;
`else
            cnt_nxt   = '0;
            state_nxt = IDLE;
`endif
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, count and (optionally) reload registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
`ifdef DECREMENT_CNT_RELOAD_EN
      reload_r <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_r  <= state_nxt;
      cnt_r    <= cnt_nxt;
`ifdef DECREMENT_CNT_RELOAD_EN
      reload_r <= reload_nxt;
`endif
    end
  end

  // Handshake outputs are pure state decodes, so no input reaches an output.
  always_comb begin
    ld_rdy   = (state_r == IDLE);
    done_vld = (state_r == DONE);
    busy_r   = (state_r != IDLE);
  end

endmodule
